// File: rtl/led_driver.sv
// Serialises a parallel LED pattern onto a data+latch shift-register chain.
// Each frame snapshots i_data, shifts it out, pulses latch, then idles.
module led_driver #(
  parameter int DATA_W     = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_LEDdata,
  output logic              o_LEDlatch
);

  localparam int CW       = $clog2(DATA_W) + 1;
  localparam int IW       = $clog2(DATA_W);
  localparam int GW       = $clog2(GAP_CYCLES + 1) + 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    LATCH,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [IW-1:0]     idx;
  logic              data_d, latch_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      gap_q      <= '0;
      shadow_q   <= '0;
      o_LEDdata  <= 1'b0;
      o_LEDlatch <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      shadow_q   <= shadow_d;
      o_LEDdata  <= data_d;
      o_LEDlatch <= latch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    shadow_d = shadow_q;
    data_d   = 1'b0;
    latch_d  = 1'b0;
    idx      = '0;
    unique case (state_q)
      LOAD: begin
        shadow_d = i_data;
        cnt_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CW'(DATA_W - 1)) state_d = LATCH;
        else cnt_d = cnt_q + CW'(1);
      end
      LATCH: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES == 0) ? LOAD : GAP;
      end
      GAP: begin
        if (gap_q == GW'(GAP_LAST)) state_d = LOAD;
        else gap_d = gap_q + GW'(1);
      end
      default: state_d = LOAD;
    endcase
    // Outputs are registered, so they are decoded from the next state
    // to line up with the cycle that state is actually occupied.
    if (MSB_FIRST) idx = IW'(CW'(DATA_W - 1) - cnt_d);
    else idx = IW'(cnt_d);
    if (state_d == SHIFT) data_d = shadow_d[idx];
    if (state_d == LATCH) latch_d = 1'b1;
  end

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver: default, LSB-first and zero-gap variants
// share one clock and reset; frames are captured on the falling edge.
module tb_led_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] d0, d1, d2;
  logic        o_data0, o_latch0;
  logic        o_data1, o_latch1;
  logic        o_data2, o_latch2;

  int checks;
  int failures;

  led_driver u_dut0 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_data    (d0),
    .o_LEDdata (o_data0),
    .o_LEDlatch(o_latch0)
  );

  led_driver #(.MSB_FIRST(1'b0)) u_dut1 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_data    (d1),
    .o_LEDdata (o_data1),
    .o_LEDlatch(o_latch1)
  );

  led_driver #(.GAP_CYCLES(0)) u_dut2 (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_data    (d2),
    .o_LEDdata (o_data2),
    .o_LEDlatch(o_latch2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge while u_dut0 sits in LOAD; returns at the
  // falling edge of the following LOAD cycle.
  task automatic cap_frame(
    input  int          chg_at,
    input  logic [15:0] chg_val,
    output logic [15:0] ser,
    output logic [15:0] ser1,
    output int          lpos,
    output int          lcnt,
    output int          maxrun,
    output int          idle_bad
  );
    int run;
    ser      = '0;
    ser1     = '0;
    lpos     = -1;
    lcnt     = 0;
    maxrun   = 0;
    run      = 0;
    idle_bad = 0;
    if (o_data0 || o_latch0) idle_bad++;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == chg_at) d0 = chg_val;
      if (j <= 16) begin
        ser  = {ser[14:0], o_data0};
        ser1 = {ser1[14:0], o_data1};
      end else if (o_data0) begin
        idle_bad++;
      end
      if (o_latch0) begin
        lcnt++;
        lpos = j;
      end
      if (o_data0) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic wait_latch2(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_latch2 && n < 60);
  endtask

  logic [15:0] ser, ser1;
  int lpos, lcnt, maxrun, idle_bad, n;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    d0       = 16'h00FF;
    d1       = 16'h0001;
    d2       = 16'h00FF;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_data", int'(o_data0), 0);
      check("rst_latch", int'(o_latch0), 0);
    end
    rst_n = 1'b1;

    cap_frame(0, 16'h0, ser, ser1, lpos, lcnt, maxrun, idle_bad);
    check("basic_ser", int'(ser), 16'h00FF);
    check("basic_lpos", lpos, 17);
    check("basic_lcnt", lcnt, 1);
    check("basic_idle", idle_bad, 0);
    check("lsb_first_ser", int'(ser1), 16'h8000);

    d0 = 16'hA5C3;
    for (int f = 0; f < 5; f++) begin
      cap_frame(0, 16'h0, ser, ser1, lpos, lcnt, maxrun, idle_bad);
      check("period_ser", int'(ser), 16'hA5C3);
      check("period_lpos", lpos, 17);
      check("period_lcnt", lcnt, 1);
    end

    d0 = 16'h00FF;
    cap_frame(5, 16'hFF00, ser, ser1, lpos, lcnt, maxrun, idle_bad);
    check("midchg_cur", int'(ser), 16'h00FF);
    cap_frame(0, 16'h0, ser, ser1, lpos, lcnt, maxrun, idle_bad);
    check("midchg_next", int'(ser), 16'hFF00);

    d0 = 16'h0000;
    cap_frame(0, 16'h0, ser, ser1, lpos, lcnt, maxrun, idle_bad);
    check("zero_ser", int'(ser), 0);
    check("zero_run", maxrun, 0);

    d0 = 16'hFFFF;
    cap_frame(0, 16'h0, ser, ser1, lpos, lcnt, maxrun, idle_bad);
    check("ones_ser", int'(ser), 16'hFFFF);
    check("ones_run", maxrun, 16);
    check("ones_idle", idle_bad, 0);
    check("ones_lpos", lpos, 17);

    for (int i = 0; i < 3; i++) @(negedge clk);
    check("pre_rst_data", int'(o_data0), 1);
    #5 rst_n = 1'b0;
    #1;
    check("async_rst_data", int'(o_data0), 0);
    check("async_rst_latch", int'(o_latch0), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold_rst_latch", int'(o_latch0), 0);
    end
    d0    = 16'h00FF;
    rst_n = 1'b1;
    cap_frame(0, 16'h0, ser, ser1, lpos, lcnt, maxrun, idle_bad);
    check("restart_ser", int'(ser), 16'h00FF);
    check("restart_lpos", lpos, 17);

    wait_latch2(n);
    check("gap0_found", int'(o_latch2), 1);
    wait_latch2(n);
    check("gap0_period_a", n, 18);
    wait_latch2(n);
    check("gap0_period_b", n, 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
